// File: rtl/debounce_scheduler_if.sv
// Key-scan bus between the debounce scheduler and the user logic.
// The scheduler takes the slave side: it reads enable and the raw keys and
// drives the debounced level, the press/release pulses and the scan status.
interface debounce_scheduler_if #(
   parameter int NUM_KEYS = 4
);
   localparam int IDX_W = $clog2(NUM_KEYS);

   logic                enable;
   logic [NUM_KEYS-1:0] key_in;
   logic [NUM_KEYS-1:0] key_level;
   logic [NUM_KEYS-1:0] key_press;
   logic [NUM_KEYS-1:0] key_release;
   logic                scan_tick;
   logic [IDX_W-1:0]    scan_idx;

   modport master (
      output enable,
      output key_in,
      input  key_level,
      input  key_press,
      input  key_release,
      input  scan_tick,
      input  scan_idx
   );

   modport slave (
      input  enable,
      input  key_in,
      output key_level,
      output key_press,
      output key_release,
      output scan_tick,
      output scan_idx
   );
endinterface

// File: rtl/debounce_scheduler.sv
// Multi-key debounce controller. One shared divider produces a service tick;
// each tick services one channel in round-robin order, so every key is
// sampled at SAMPLE_FREQ. A channel accepts a level change only after
// STABLE_N consecutive equal samples.
// Build option: define DEBOUNCE_REPEAT_EN to add per-key auto-repeat of
// key_press every REPEAT_SAMPLES all-ones services while a key is held.
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_RELEASED | debounced level 0, waiting for STABLE_N ones
// ST_PRESSED  | debounced level 1, waiting for STABLE_N zeros
module debounce_scheduler #(
   parameter int SYS_CLK_FREQ   = 100_000_000,
   parameter int SAMPLE_FREQ    = 1_000,
   parameter int NUM_KEYS       = 4,
   parameter int STABLE_N       = 8,
   parameter int REPEAT_SAMPLES = 64
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   debounce_scheduler_if.slave   kbus
);

   localparam int CNT_MAX = SYS_CLK_FREQ / (SAMPLE_FREQ * NUM_KEYS);
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam int IDX_W   = $clog2(NUM_KEYS);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_KEYS - 1);

   generate
      if (CNT_MAX < 2) begin : g_bad_cnt_max
         $error("debounce_scheduler: divider ratio below 2, sample rate too high");
      end
      if (NUM_KEYS < 2 || NUM_KEYS > 16) begin : g_bad_num_keys
         $error("debounce_scheduler: NUM_KEYS must be 2..16");
      end
      if (STABLE_N < 2 || STABLE_N > 32) begin : g_bad_stable_n
         $error("debounce_scheduler: STABLE_N must be 2..32");
      end
      if (REPEAT_SAMPLES < 1) begin : g_bad_repeat
         $error("debounce_scheduler: REPEAT_SAMPLES must be at least 1");
      end
   endgenerate

   typedef enum logic {
      ST_RELEASED = 1'b0,
      ST_PRESSED  = 1'b1
   } key_state_t;

   logic [CNT_W-1:0]    div_cnt_q;
   logic                scan_tick_q;
   logic [IDX_W-1:0]    scan_idx_q;
   logic [NUM_KEYS-1:0] sync1_q;
   logic [NUM_KEYS-1:0] sync2_q;
   logic [STABLE_N-1:0] sr_q [NUM_KEYS];
   key_state_t          ch_state_q [NUM_KEYS];
   logic [NUM_KEYS-1:0] key_level_q;
   logic [NUM_KEYS-1:0] key_press_q;
   logic [NUM_KEYS-1:0] key_release_q;

   logic [STABLE_N-1:0] svc_sr;
   logic                svc_ones;
   logic                svc_zeros;

`ifdef DEBOUNCE_REPEAT_EN
   localparam int RPT_W = (REPEAT_SAMPLES < 2) ? 1 : $clog2(REPEAT_SAMPLES);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_SAMPLES - 1);

   logic [RPT_W-1:0]    rpt_cnt_q [NUM_KEYS];
`endif

   // Shared tick divider; disabling clears it so a restart always waits a full period.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         div_cnt_q   <= '0;
         scan_tick_q <= 1'b0;
      end else if (!kbus.enable) begin
         div_cnt_q   <= '0;
         scan_tick_q <= 1'b0;
      end else if (div_cnt_q == CNT_LAST) begin
         div_cnt_q   <= '0;
         scan_tick_q <= 1'b1;
      end else begin
         div_cnt_q   <= div_cnt_q + CNT_W'(1);
         scan_tick_q <= 1'b0;
      end
   end

   // Two-flop synchronizer for the asynchronous raw key levels.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= kbus.key_in;
         sync2_q <= sync1_q;
      end
   end

   // Shift history of the channel being serviced, including the new sample.
   always_comb begin
      svc_sr    = '0;
      svc_sr    = {sr_q[scan_idx_q][STABLE_N-2:0], sync2_q[scan_idx_q]};
      svc_ones  = &svc_sr;
      svc_zeros = ~|svc_sr;
   end

   // Round-robin service: shift the sample in, advance the channel FSM, pulse outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         scan_idx_q    <= '0;
         key_level_q   <= '0;
         key_press_q   <= '0;
         key_release_q <= '0;
         for (int k = 0; k < NUM_KEYS; k++) begin
            sr_q[k]       <= '0;
            ch_state_q[k] <= ST_RELEASED;
`ifdef DEBOUNCE_REPEAT_EN
            rpt_cnt_q[k]  <= '0;
`endif
         end
      end else begin
         key_press_q   <= '0;
         key_release_q <= '0;
         if (scan_tick_q) begin
            sr_q[scan_idx_q] <= svc_sr;
            scan_idx_q       <= (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
            if (ch_state_q[scan_idx_q] == ST_RELEASED) begin
               if (svc_ones) begin
                  ch_state_q[scan_idx_q]  <= ST_PRESSED;
                  key_level_q[scan_idx_q] <= 1'b1;
                  key_press_q[scan_idx_q] <= 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
                  rpt_cnt_q[scan_idx_q]   <= '0;
`endif
               end
            end else begin
               if (svc_zeros) begin
                  ch_state_q[scan_idx_q]    <= ST_RELEASED;
                  key_level_q[scan_idx_q]   <= 1'b0;
                  key_release_q[scan_idx_q] <= 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
                  rpt_cnt_q[scan_idx_q]     <= '0;
               end else if (svc_ones) begin
                  // Held key: every REPEAT_SAMPLES-th all-ones service re-fires key_press.
                  if (rpt_cnt_q[scan_idx_q] == RPT_LAST) begin
                     rpt_cnt_q[scan_idx_q]   <= '0;
                     key_press_q[scan_idx_q] <= 1'b1;
                  end else begin
                     rpt_cnt_q[scan_idx_q] <= rpt_cnt_q[scan_idx_q] + RPT_W'(1);
                  end
`endif
               end
            end
         end
      end
   end

   assign kbus.scan_tick   = scan_tick_q;
   assign kbus.scan_idx    = scan_idx_q;
   assign kbus.key_level   = key_level_q;
   assign kbus.key_press   = key_press_q;
   assign kbus.key_release = key_release_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: directed scenarios followed by random key and
// enable activity, every cycle compared against a sample-history model.
module tb_debounce_scheduler;

   localparam int NK      = 4;
   localparam int SN      = 4;
   localparam int CNT_MAX = 5;
   localparam int REP     = 3;

   logic sys_clk;
   logic sys_rst_n;

   debounce_scheduler_if #(.NUM_KEYS(NK)) bus ();

   debounce_scheduler #(
      .SYS_CLK_FREQ   (1000),
      .SAMPLE_FREQ    (50),
      .NUM_KEYS       (NK),
      .STABLE_N       (SN),
      .REPEAT_SAMPLES (REP)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .kbus      (bus)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int pcnt [NK];
   int rcnt [NK];

   // Reference model: per key, the last sample and how many times in a row it was seen.
   int          m_run;
   bit          m_tick;
   int          m_idx;
   logic [NK-1:0] m_s1, m_s2, m_last, m_lvl, m_prs, m_rel;
   int          m_runlen [NK];
   int          m_held   [NK];

`ifdef DEBOUNCE_REPEAT_EN
   int press_cyc[$];
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_tick = 0; m_idx = 0;
      m_s1 = '0; m_s2 = '0; m_last = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
      for (int k = 0; k < NK; k++) begin
         m_runlen[k] = SN;
         m_held[k]   = 0;
      end
   endtask

   task automatic model_update();
      int  ch;
      bit  smp, ones, zeros;
      if (!sys_rst_n) begin
         model_reset();
         return;
      end
      m_prs = '0;
      m_rel = '0;
      if (m_tick) begin
         ch  = m_idx;
         smp = m_s2[ch];
         if (smp == m_last[ch]) m_runlen[ch]++;
         else begin
            m_last[ch]   = smp;
            m_runlen[ch] = 1;
         end
         ones  = (m_last[ch] == 1'b1) && (m_runlen[ch] >= SN);
         zeros = (m_last[ch] == 1'b0) && (m_runlen[ch] >= SN);
         if (!m_lvl[ch] && ones) begin
            m_lvl[ch] = 1'b1; m_prs[ch] = 1'b1; m_held[ch] = 0;
         end else if (m_lvl[ch] && zeros) begin
            m_lvl[ch] = 1'b0; m_rel[ch] = 1'b1; m_held[ch] = 0;
         end
`ifdef DEBOUNCE_REPEAT_EN
         else if (m_lvl[ch] && ones) begin
            m_held[ch]++;
            if (m_held[ch] % REP == 0) m_prs[ch] = 1'b1;
         end
`endif
         m_idx = (ch + 1) % NK;
      end
      m_s2 = m_s1;
      m_s1 = bus.key_in;
      if (bus.enable) begin
         m_run++;
         m_tick = (m_run % CNT_MAX == 0);
      end else begin
         m_run  = 0;
         m_tick = 0;
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      model_update();
      #1;
      cyc++;
      check("scan_tick",   bus.scan_tick,   m_tick);
      check("scan_idx",    bus.scan_idx,    m_idx);
      check("key_level",   bus.key_level,   m_lvl);
      check("key_press",   bus.key_press,   m_prs);
      check("key_release", bus.key_release, m_rel);
      for (int k = 0; k < NK; k++) begin
         if (bus.key_press[k])   pcnt[k]++;
         if (bus.key_release[k]) rcnt[k]++;
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic clear_counts();
      for (int k = 0; k < NK; k++) begin
         pcnt[k] = 0;
         rcnt[k] = 0;
      end
   endtask

   initial begin
      int n;
      int idx_hold;
      int en_gap;
      int bouncy;

      sys_rst_n   = 1'b0;
      bus.enable  = 1'b1;
      bus.key_in  = 4'b1111;
      model_reset();
      clear_counts();

      // Reset held with all keys pressed: everything stays at zero.
      run(3);
      check("rst_level", bus.key_level, 0);
      bus.key_in = 4'b0000;
      sys_rst_n  = 1'b1;

      // First tick arrives CNT_MAX cycles after reset release, on channel 0.
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.scan_tick && n < 20);
      check("first_tick_delay", n, 5);
      check("first_tick_idx", bus.scan_idx, 0);

      // Clean press of key 2.
      clear_counts();
      bus.key_in = 4'b0100;
      run(120);
      check("press2_count", pcnt[2], 1);
      check("press2_others", pcnt[0] + pcnt[1] + pcnt[3], 0);
      check("press2_level", bus.key_level, 4'b0100);

      // Key 1 bouncing every 7 cycles must never be accepted.
      clear_counts();
      for (int i = 0; i < 200; i++) begin
         if (i % 7 == 0) bus.key_in[1] = ~bus.key_in[1];
         step();
      end
      check("bounce1_no_press", pcnt[1], 0);
      clear_counts();
      bus.key_in[1] = 1'b1;
      run(120);
      check("settle1_press", pcnt[1], 1);

      // Release of key 2.
      clear_counts();
      bus.key_in[2] = 1'b0;
      run(120);
      check("release2_count", rcnt[2], 1);
      check("release2_level", bus.key_level[2], 0);

      // Scan frozen for 37 cycles.
      bus.enable = 1'b0;
      step();
      idx_hold = bus.scan_idx;
      for (int i = 0; i < 36; i++) begin
         step();
         check("gap_tick", bus.scan_tick, 0);
         check("gap_idx", bus.scan_idx, idx_hold);
      end
      bus.enable = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.scan_tick && n < 20);
      check("resume_delay", n, 5);
      check("resume_idx", bus.scan_idx, idx_hold);

      // Asynchronous reset while key 0 is pressed.
      bus.key_in = 4'b0001;
      run(120);
      check("key0_pressed", bus.key_level[0], 1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("async_level_clear", bus.key_level, 0);
      check("async_tick_clear", bus.scan_tick, 0);
      model_reset();
      bus.key_in = 4'b0000;
      clear_counts();
      run(2);
      sys_rst_n = 1'b1;
      run(100);
      check("no_release_after_rst", rcnt[0], 0);

      // Long hold of key 0: single press, or periodic repeats when enabled.
      clear_counts();
      bus.key_in[0] = 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
      for (int i = 0; i < 400; i++) begin
         step();
         if (bus.key_press[0]) press_cyc.push_back(cyc);
      end
      check("repeat_count_min", press_cyc.size() >= 4, 1);
      for (int i = 1; i < press_cyc.size(); i++)
         check("repeat_gap", press_cyc[i] - press_cyc[i-1], 60);
`else
      run(400);
      check("hold_single_press", pcnt[0], 1);
`endif
      bus.key_in[0] = 1'b0;
      run(120);

      // Random key activity with bouncy keys and enable dropouts.
      en_gap = 0;
      bouncy = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) bouncy = $urandom_range(0, NK);
         for (int k = 0; k < NK; k++) begin
            if (k == bouncy) begin
               if ($urandom_range(0, 2) == 0) bus.key_in[k] = ~bus.key_in[k];
            end else if ($urandom_range(0, 59) == 0) begin
               bus.key_in[k] = ~bus.key_in[k];
            end
         end
         if (en_gap > 0) begin
            en_gap--;
            bus.enable = 1'b0;
         end else begin
            bus.enable = 1'b1;
            if ($urandom_range(0, 399) == 0) en_gap = $urandom_range(1, 40);
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Multi-key debounce controller that shares one internal sample-enable tick across NUM_KEYS inputs.
- Each tick services one channel: it shifts that channel's synchronized level into its shift register and advances that channel's press/release FSM.
- Round-robin sequencing gives every key the same sample rate (SAMPLE_FREQ) from a single divider.
- Sits between raw board buttons and the user-logic key interface.

Parameters:
- SYS_CLK_FREQ, 100_000_000, system clock frequency in Hz.
- SAMPLE_FREQ, 1_000, per-key sample rate in Hz.
- NUM_KEYS, 4, number of key channels (2..16).
- STABLE_N, 8, consecutive equal samples needed to accept a level change (2..32).
- REPEAT_SAMPLES, 64, auto-repeat interval in per-key samples. Used only with DEBOUNCE_REPEAT_EN.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = scanning runs; 0 = scan frozen.
- key_in  input  NUM_KEYS  raw key levels, 1 = pressed, asynchronous to sys_clk.
- key_level  output  NUM_KEYS  debounced level per key.
- key_press  output  NUM_KEYS  one-cycle pulse on accepted press.
- key_release  output  NUM_KEYS  one-cycle pulse on accepted release.
- scan_tick  output  1  one-cycle pulse on each service tick.
- scan_idx  output  clog2(NUM_KEYS)  channel serviced at the current or last tick.

Behaviour:
- Reset (async assert, sync release): divider, scan_idx, synchronizers, shift registers, FSMs and all outputs go to 0.
- Divider:
  - CNT_MAX = SYS_CLK_FREQ / (SAMPLE_FREQ * NUM_KEYS). Elaboration error if CNT_MAX < 2.
  - Counter width = clog2(CNT_MAX). Counts 0..CNT_MAX-1 and wraps to 0.
  - scan_tick is registered and asserted in the cycle after the edge where the counter equals CNT_MAX-1.
- Synchronizer: 2-flop synchronizer per key_in bit. Sampling uses the second-stage value (sync_k).
- Tick service: at the edge where scan_tick=1, channel i = scan_idx.
  - new_sr = {sr_i[STABLE_N-2:0], sync_i}; sr_i <= new_sr.
  - scan_idx <= i+1, wrapping NUM_KEYS-1 -> 0.
- Per-channel FSM, states RELEASED and PRESSED, evaluated only when servicing that channel:
  - RELEASED and new_sr all ones -> PRESSED; key_level[i] <= 1; key_press[i] <= 1.
  - PRESSED and new_sr all zeros -> RELEASED; key_level[i] <= 0; key_release[i] <= 1.
  - Otherwise the state holds. Bouncing input keeps a mixed sr, so no transition.
- Pulses: key_press/key_release are high exactly one cycle; all other cycles 0. At most one channel pulses per cycle.
- Latency: an accepted change fires STABLE_N services of that channel after the input settles, plus 2 synchronizer cycles plus at most one scan period.
- enable=0:
  - Divider cleared to 0; scan_tick held 0; scan_idx, shift registers, FSMs and key_level hold.
  - A pulse already in flight completes.
  - On return to enable=1, the first tick comes CNT_MAX cycles later and resumes at the held scan_idx.
- Reset mid-operation clears PRESSED keys to RELEASED without emitting key_release.

Optional Feature:
- Macro DEBOUNCE_REPEAT_EN.
- Defined: each channel has a repeat counter, cleared on entry to PRESSED.
  - While PRESSED, each service of that channel with new_sr all ones increments the counter.
  - When the counter reaches REPEAT_SAMPLES-1, it reloads to 0 and key_press[i] pulses again.
  - Leaving PRESSED clears the counter.
- Undefined: no repeat counters; key_press pulses once per press.

Test Plan:
All tests use SYS_CLK_FREQ=1000, SAMPLE_FREQ=50, NUM_KEYS=4, STABLE_N=4, giving CNT_MAX=5, a tick every 5 cycles and each key sampled every 20 cycles.
- Reset with key_in=4'b1111 -> all outputs 0 during reset. After release, scan_tick first pulses 5 cycles after the first enabled edge, with scan_idx=0.
- key_in[2] held at 1 from cycle 0 -> exactly one key_press[2] pulse on the 4th service of channel 2. key_level=4'b0100; no other pulses.
- key_in[1] toggles every 7 cycles for 200 cycles, then held at 1 -> no key_press[1] during the toggling. One pulse 4 services of channel 1 after it goes stable.
- key 2 pressed, then key_in[2]=0 -> one key_release[2] pulse after 4 channel-2 services. key_level[2]=0.
- enable=0 for 37 cycles mid-scan -> scan_tick stays 0 and scan_idx is unchanged. The next tick occurs 5 cycles after enable returns.
- sys_rst_n pulsed low between clock edges while key 0 is PRESSED -> key_level clears immediately without a clock edge, and no key_release pulse follows.
- With DEBOUNCE_REPEAT_EN and REPEAT_SAMPLES=3, key 0 held -> an initial key_press[0], then further key_press[0] pulses every 3 channel-0 services (every 60 cycles).
